mc_alu_sequencer: RTL and testbench

Execute-stage sequencer for the two multi-cycle ALU operations, ANN (ALUControlE = 3'b100) and WGHT (ALUControlE = 3'b101).
- Detects a multi-cycle op entering Execute.
- Pulses a start to the ALU's multi-cycle path, holds the instruction in Execute for the op's latency, then releases the pipeline.
- Sits beside the hazard logic; its stall outputs are OR-ed into StallF/StallD and the Execute register enable, and FlushM inserts bubbles into Memory.

---
 rtl/mc_alu_sequencer.sv | 143 ++++++++++++++
 tb/tb_mc_alu_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mc_alu_sequencer
// Description : Execute-stage sequencer for the multi-cycle ANN/WGHT ALU ops.
//               Optional stall performance counter: define MC_ALU_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_alu_sequencer #(
    parameter int ANN_LAT  = 4,
    parameter int WGHT_LAT = 3,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ValidE,
    input  logic [2:0]       ALUControlE,
    output logic             MCStallF,
    output logic             MCStallD,
    output logic             MCStallE,
    output logic             FlushM,
    output logic             UnitStartE,
    output logic             UnitOpE,
    output logic             BusyE,
    output logic             ResultValidE
`ifdef MC_ALU_PERF_EN
    ,
    output logic [CNT_W-1:0] StallCycles
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Counter preload: the issue cycle and the DONE cycle are not counted.
    localparam logic [3:0] c_ANN_LOAD  = 4'(ANN_LAT - 2);
    localparam logic [3:0] c_WGHT_LOAD = 4'(WGHT_LAT - 2);

    generate
        if (ANN_LAT < 2 || ANN_LAT > 15) begin : g_annLatCheck
            $error("mc_alu_sequencer: ANN_LAT must be in 2..15");
        end
        if (WGHT_LAT < 2 || WGHT_LAT > 15) begin : g_wghtLatCheck
            $error("mc_alu_sequencer: WGHT_LAT must be in 2..15");
        end
        if (CNT_W < 1) begin : g_cntWCheck
            $error("mc_alu_sequencer: CNT_W must be at least 1");
        end
    endgenerate

    state_t     r_state;
    state_t     w_nextState;
    logic [3:0] r_cnt;
    logic [3:0] w_nextCnt;
    logic [3:0] w_load;
    logic       r_unitOp;
    logic       w_nextUnitOp;
    logic       w_live;
    logic       w_isMc;
    logic       w_issue;
    logic       w_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_unitOp <= 1'b0;
        end else begin
            r_state  <= w_nextState;
            r_cnt    <= w_nextCnt;
            r_unitOp <= w_nextUnitOp;
        end
    end

    always_comb begin
        w_nextState  = r_state;
        w_nextCnt    = r_cnt;
        w_nextUnitOp = r_unitOp;
        w_load       = ALUControlE[0] ? c_WGHT_LOAD : c_ANN_LOAD;
        // Reset also masks the outputs combinationally, so nothing leaks out
        // during the reset cycle itself.
        w_live       = ~reset;
        w_isMc       = (ALUControlE == 3'b100) || (ALUControlE == 3'b101);
        w_issue      = w_live && (r_state == S_IDLE) && ValidE && w_isMc;

        case (r_state)
            S_IDLE: begin
                if (w_issue) begin
                    w_nextUnitOp = ALUControlE[0];
                    w_nextCnt    = w_load;
                    w_nextState  = (w_load == 4'd0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (r_cnt <= 4'd1) begin
                    w_nextState = S_DONE;
                end else begin
                    w_nextCnt = r_cnt - 4'd1;
                end
            end
            S_DONE: begin
                w_nextState  = S_IDLE;
                w_nextCnt    = 4'd0;
                w_nextUnitOp = 1'b0;
            end
            default: begin
                w_nextState  = S_IDLE;
                w_nextCnt    = 4'd0;
                w_nextUnitOp = 1'b0;
            end
        endcase

        w_stall      = w_issue || (w_live && (r_state == S_RUN));
        MCStallF     = w_stall;
        MCStallD     = w_stall;
        MCStallE     = w_stall;
        FlushM       = w_stall;
        UnitStartE   = w_issue;
        // The op code is visible in the issue cycle before it is latched.
        UnitOpE      = (r_state == S_IDLE) ? (w_issue && ALUControlE[0])
                                           : (w_live && r_unitOp);
        BusyE        = w_live && (r_state != S_IDLE);
        ResultValidE = w_live && (r_state == S_DONE);
    end

`ifdef MC_ALU_PERF_EN
    logic [CNT_W-1:0] r_stallCycles;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stallCycles <= '0;
        end else if (w_stall && (r_stallCycles != {CNT_W{1'b1}})) begin
            r_stallCycles <= r_stallCycles + CNT_W'(1);
        end
    end

    assign StallCycles = r_stallCycles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mc_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_alu_sequencer
// Description : Directed self-checking bench for mc_alu_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_alu_sequencer;

    localparam int TB_CNT_W = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ValidE = 1'b0;
    logic [2:0] ALUControlE = 3'b000;

    logic stF, stD, stE, flM, start, op, busy, rv;
    logic stF2, stD2, stE2, flM2, start2, op2, busy2, rv2;
`ifdef MC_ALU_PERF_EN
    logic [TB_CNT_W-1:0] stallCycles;
    logic [TB_CNT_W-1:0] stallCycles2;
`endif

    int nTests = 0;
    int nFail  = 0;

    // {MCStallF, MCStallD, MCStallE, FlushM, UnitStartE, UnitOpE, BusyE, ResultValidE}
    logic [7:0] outs;
    logic [7:0] outs2;
    assign outs  = {stF, stD, stE, flM, start, op, busy, rv};
    assign outs2 = {stF2, stD2, stE2, flM2, start2, op2, busy2, rv2};

    always #5 clk = ~clk;

    mc_alu_sequencer #(.ANN_LAT(4), .WGHT_LAT(3), .CNT_W(TB_CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .ValidE       (ValidE),
        .ALUControlE  (ALUControlE),
        .MCStallF     (stF),
        .MCStallD     (stD),
        .MCStallE     (stE),
        .FlushM       (flM),
        .UnitStartE   (start),
        .UnitOpE      (op),
        .BusyE        (busy),
        .ResultValidE (rv)
`ifdef MC_ALU_PERF_EN
        ,
        .StallCycles  (stallCycles)
`endif
    );

    mc_alu_sequencer #(.ANN_LAT(2), .WGHT_LAT(3), .CNT_W(TB_CNT_W)) dut2 (
        .clk          (clk),
        .reset        (reset),
        .ValidE       (ValidE),
        .ALUControlE  (ALUControlE),
        .MCStallF     (stF2),
        .MCStallD     (stD2),
        .MCStallE     (stE2),
        .FlushM       (flM2),
        .UnitStartE   (start2),
        .UnitOpE      (op2),
        .BusyE        (busy2),
        .ResultValidE (rv2)
`ifdef MC_ALU_PERF_EN
        ,
        .StallCycles  (stallCycles2)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        ValidE      = 1'b0;
        ALUControlE = 3'b000;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        ValidE      = 1'b1;
        ALUControlE = 3'b100;
        for (int i = 0; i < 2; i++) begin
            #4;
            nTests++;
            if (outs !== 8'h00 || outs2 !== 8'h00) begin
                nFail++;
                $display("FAIL reset_hold cyc%0d: got %b/%b expected 00000000", i, outs, outs2);
            end
            tick();
        end
        reset       = 1'b0;
        ALUControlE = 3'b000;
        for (int i = 0; i < 5; i++) begin
            #4;
            nTests++;
            if (outs !== 8'h00) begin
                nFail++;
                $display("FAIL reset_add cyc%0d: got %b expected 00000000", i, outs);
            end
            tick();
        end
    endtask

    task automatic test_ann();
        logic [7:0] expv [0:4] = '{8'hF8, 8'hF2, 8'hF2, 8'h03, 8'h00};
        logic       vv   [0:4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            ValidE      = vv[i];
            ALUControlE = 3'b100;
            #4;
            nTests++;
            if (outs !== expv[i]) begin
                nFail++;
                $display("FAIL ann t+%0d: got %b expected %b", i, outs, expv[i]);
            end
            tick();
        end
        idle(2);
    endtask

    task automatic test_back_to_back();
        logic [7:0] expv [0:7] = '{8'hFC, 8'hF6, 8'h07, 8'hF8, 8'hF2, 8'hF2, 8'h03, 8'h00};
        logic [2:0] code [0:7] = '{3'b101, 3'b101, 3'b101, 3'b100, 3'b100, 3'b100, 3'b100, 3'b000};
        for (int i = 0; i < 8; i++) begin
            ValidE      = (i < 7);
            ALUControlE = code[i];
            #4;
            nTests++;
            if (outs !== expv[i]) begin
                nFail++;
                $display("FAIL b2b t+%0d: got %b expected %b", i, outs, expv[i]);
            end
            tick();
        end
        idle(2);
    endtask

    task automatic test_no_issue();
        logic       vv   [0:7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [2:0] code [0:7] = '{3'b100, 3'b101, 3'b000, 3'b001, 3'b010, 3'b011, 3'b110, 3'b111};
        for (int i = 0; i < 8; i++) begin
            ValidE      = vv[i];
            ALUControlE = code[i];
            #4;
            nTests++;
            if (outs !== 8'h00 || outs2 !== 8'h00) begin
                nFail++;
                $display("FAIL no_issue v=%0d code=%b: got %b/%b expected 00000000",
                         vv[i], code[i], outs, outs2);
            end
            tick();
        end
        idle(1);
    endtask

    task automatic test_lat2();
        logic [7:0] expv [0:2] = '{8'hF8, 8'h03, 8'h00};
        for (int i = 0; i < 3; i++) begin
            ValidE      = (i < 2);
            ALUControlE = 3'b100;
            #4;
            nTests++;
            if (outs2 !== expv[i]) begin
                nFail++;
                $display("FAIL lat2 t+%0d: got %b expected %b", i, outs2, expv[i]);
            end
            tick();
        end
        idle(4);
    endtask

    task automatic test_mid_reset();
        logic [7:0] expv [0:6] = '{8'hF8, 8'h00, 8'h00, 8'hFC, 8'hF6, 8'h07, 8'h00};
        logic       vv   [0:6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [2:0] code [0:6] = '{3'b100, 3'b100, 3'b000, 3'b101, 3'b101, 3'b101, 3'b000};
        for (int i = 0; i < 7; i++) begin
            reset       = (i == 1);
            ValidE      = vv[i];
            ALUControlE = code[i];
            #4;
            nTests++;
            if (outs !== expv[i]) begin
                nFail++;
                $display("FAIL mid_reset t+%0d: got %b expected %b", i, outs, expv[i]);
            end
            tick();
        end
        reset = 1'b0;
        idle(2);
    endtask

`ifdef MC_ALU_PERF_EN
    task automatic test_perf();
        int expCnt;
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        #4;
        nTests++;
        if (stallCycles !== 2'd0) begin
            nFail++;
            $display("FAIL perf_clear: got %0d expected 0", stallCycles);
        end
        #0;
        for (int opn = 0; opn < 4; opn++) begin
            for (int c = 0; c < 4; c++) begin
                ValidE      = 1'b1;
                ALUControlE = 3'b100;
                #4;
                expCnt = (opn * 3 + c > 3) ? 3 : opn * 3 + c;
                nTests++;
                if (stallCycles !== TB_CNT_W'(expCnt)) begin
                    nFail++;
                    $display("FAIL perf op%0d cyc%0d: got %0d expected %0d",
                             opn, c, stallCycles, expCnt);
                end
                tick();
            end
        end
        idle(2);
    endtask
`endif

    initial begin
        test_reset();
        test_ann();
        test_back_to_back();
        test_no_issue();
        test_lat2();
        test_mid_reset();
`ifdef MC_ALU_PERF_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
`default_nettype wire
